pio_event_sequencer: RTL
========================

Name: pio_event_sequencer

Overview:
- Services up to NCH single-bit edge-capture PIO peripherals (vending-machine buttons, coin and reset inputs) over their Avalon-MM slave ports.
- After reset it configures each PIO: writes irq_mask = 1, then clears edge_capture.
- Afterwards it arbitrates pending PIO interrupts round-robin. For each grant it reads edge_capture, clears it, and queues the channel number into an event FIFO for the control FSM.
- Spurious interrupts are counted, not queued.

Parameters:
- NCH, 4, number of PIO channels served (2..16).
- CW, 2, event code width; must equal ceil(log2(NCH)).
- DEPTH, 4, event FIFO depth (power of two, 2..16).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  NCH  irq outputs of the PIO channels; bit i belongs to channel i.
- m_chipselect  out  NCH  one-hot chipselect, bit i selects PIO i.
- m_address  out  2  PIO register offset: 2 = irq_mask, 3 = edge_capture.
- m_write_n  out  1  active-low write strobe.
- m_writedata  out  1  write data to the PIO.
- m_readdata  in  NCH  readdata of each PIO; registered in the PIO, valid 1 cycle after m_address is presented.
- ev_valid  out  1  event FIFO not empty.
- ev_ready  in  1  consumer pop; a pop occurs when ev_valid && ev_ready.
- ev_code  out  CW  channel number at FIFO head.
- init_done  out  1  high once configuration has completed.
- spurious_cnt  out  8  saturating count of grants whose captured bit read 0.

Behaviour:
- Reset values: m_chipselect = 0, m_address = 0, m_write_n = 1, m_writedata = 0, ev_valid = 0, ev_code = 0, init_done = 0, spurious_cnt = 0.
- Reset also empties the FIFO, sets rr_ptr to NCH-1, and enters INIT_MASK with ch = 0.
- Bus outputs are registered. Outside a bus cycle: m_chipselect = 0 and m_write_n = 1.
- States and transitions:
  - INIT_MASK: drive chipselect[ch], address 2, write_n 0, writedata 1 for one cycle. Next state INIT_CLR.
  - INIT_CLR: drive chipselect[ch], address 3, write_n 0, writedata 0 for one cycle. If ch = NCH-1, go to IDLE and set init_done = 1 (it stays 1 until reset). Otherwise ch + 1 and return to INIT_MASK. Init takes 2*NCH cycles.
  - IDLE: grant only if irq_in != 0 and FIFO count < DEPTH. The grant g is the first set bit of irq_in searching upward from rr_ptr+1, wrapping modulo NCH. Next state RD. If there is no grant, stay in IDLE.
  - RD: drive chipselect[g], address 3, write_n 1. Next state CHK.
  - CHK: sample m_readdata[g]. If it is 1, go to CLR. If it is 0, increment spurious_cnt (saturates at 255), set rr_ptr = g, and go to IDLE.
  - CLR: drive chipselect[g], address 3, write_n 0. In the same cycle push g into the FIFO and set rr_ptr = g. Next state IDLE.
- Latency: irq_in[i] high in IDLE at cycle t gives RD at t+1, CHK at t+2, CLR at t+3, and ev_valid = 1 with ev_code = i at t+4 (FIFO previously empty).
- Minimum service period is 4 cycles per event.
- irq_in changes during RD, CHK or CLR are ignored until the next IDLE.
- An edge arriving after the read but before the clear is lost; the PIO clears it. This is accepted behaviour.
- FIFO is first-word-fall-through. ev_code is valid whenever ev_valid = 1.
- Simultaneous push and pop is allowed at any fill level, and the count is unchanged.
- The full check happens only at grant. At most one push follows each grant, so overflow is impossible.
- While the FIFO is full, no grant is issued. Pending edges remain latched in the PIOs, which provides the backpressure.
- Popping while empty has no effect.
- Reset mid-operation (any state, including CLR) aborts the bus cycle and applies all reset values on the next edge.
- After such a reset, the full init sequence re-clears every edge_capture.

Test Plan:
- Reset, then idle PIO models → 8 writes in order: ch0 a2 d1, ch0 a3, ch1 a2 d1, … ch3 a3; init_done rises at cycle 8; no events queued.
- Pulse channel 2 (irq_in = 4'b0100, captured bit 1) at cycle t → read of ch2 a3 at t+1, write ch2 a3 at t+3, ev_valid at t+4 with ev_code = 2; pop → ev_valid = 0.
- irq_in = 4'b1011 held until each channel is cleared, with rr_ptr = 3 after init → service order 0, 1, 3; ev_code sequence 0, 1, 3.
- ev_ready = 0 with 5 staggered events on channels 0..3 → 4 queued, then no chipselect activity while full; one pop → fifth event serviced within 4 cycles of the pop.
- irq_in[1] = 1 but PIO1 readdata = 0 → no clear write, no push, spurious_cnt = 1; repeat 300 times → spurious_cnt = 255.
- Assert reset during CLR of channel 3 → outputs return to reset values next cycle, FIFO empty, init sequence restarts at ch0.

Source files
------------

// File: rtl/pio_event_sequencer.sv
// Configures and services a bank of edge-capture PIOs over Avalon-MM.
// Pending PIO interrupts are granted round-robin and queued as channel codes.
module pio_event_sequencer #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CW    = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] irq_in,
  output logic [NCH-1:0] m_chipselect,
  output logic [1:0]     m_address,
  output logic           m_write_n,
  output logic           m_writedata,
  input  logic [NCH-1:0] m_readdata,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [CW-1:0]  ev_code,
  output logic           init_done,
  output logic [7:0]     spurious_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [1:0] AddrMask = 2'd2;
  localparam logic [1:0] AddrEdge = 2'd3;
  localparam logic [CW-1:0] LastCh = CW'(NCH - 1);
  localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StInitMask,
    StInitClr,
    StIdle,
    StRd,
    StChk,
    StClr
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [CW-1:0]  g_q, g_d;
  logic [CW-1:0]  rr_q, rr_d;
  logic           init_done_d;
  logic [7:0]     spur_d;
  logic [NCH-1:0] cs_d;
  logic [1:0]     addr_d;
  logic           wr_n_d;
  logic           wdata_d;
  logic           push;
  logic           pop;
  logic           gnt_found;
  logic [CW-1:0]  gnt_idx;

  logic [CW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [AW:0]    count_q;

  function automatic logic [NCH-1:0] onehot(input logic [CW-1:0] i);
    logic [NCH-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First requesting channel above rr_q, wrapping modulo NCH.
  always_comb begin
    logic [CW:0] idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = {1'b0, rr_q} + (CW + 1)'(k);
      if (idx >= (CW + 1)'(NCH)) idx = idx - (CW + 1)'(NCH);
      if (!gnt_found && irq_in[idx[CW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[CW-1:0];
      end
    end
  end

  // Bus outputs are registered from the next-state decode, so each bus cycle
  // coincides with the state that owns it.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    g_d         = g_q;
    rr_d        = rr_q;
    init_done_d = init_done;
    spur_d      = spurious_cnt;
    cs_d        = '0;
    addr_d      = m_address;
    wr_n_d      = 1'b1;
    wdata_d     = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      StInitMask: begin
        // Right after reset the mask write is not yet on the bus; launch it first.
        if (!m_write_n && m_address == AddrMask) begin
          state_d = StInitClr;
          cs_d    = onehot(ch_q);
          addr_d  = AddrEdge;
          wr_n_d  = 1'b0;
        end else begin
          cs_d    = onehot(ch_q);
          addr_d  = AddrMask;
          wr_n_d  = 1'b0;
          wdata_d = 1'b1;
        end
      end
      StInitClr: begin
        if (ch_q == LastCh) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = StInitMask;
          cs_d    = onehot(ch_d);
          addr_d  = AddrMask;
          wr_n_d  = 1'b0;
          wdata_d = 1'b1;
        end
      end
      StIdle: begin
        if (gnt_found && count_q < DepthCnt) begin
          g_d     = gnt_idx;
          state_d = StRd;
          cs_d    = onehot(gnt_idx);
          addr_d  = AddrEdge;
        end
      end
      StRd: state_d = StChk;
      StChk: begin
        if (m_readdata[g_q]) begin
          state_d = StClr;
          cs_d    = onehot(g_q);
          addr_d  = AddrEdge;
          wr_n_d  = 1'b0;
        end else begin
          if (spurious_cnt != 8'hff) spur_d = spurious_cnt + 8'd1;
          rr_d    = g_q;
          state_d = StIdle;
        end
      end
      StClr: begin
        push    = 1'b1;
        rr_d    = g_q;
        state_d = StIdle;
      end
      default: state_d = StInitMask;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StInitMask;
      ch_q         <= '0;
      g_q          <= '0;
      rr_q         <= LastCh;
      init_done    <= 1'b0;
      spurious_cnt <= 8'd0;
      m_chipselect <= '0;
      m_address    <= 2'd0;
      m_write_n    <= 1'b1;
      m_writedata  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      g_q          <= g_d;
      rr_q         <= rr_d;
      init_done    <= init_done_d;
      spurious_cnt <= spur_d;
      m_chipselect <= cs_d;
      m_address    <= addr_d;
      m_write_n    <= wr_n_d;
      m_writedata  <= wdata_d;
    end
  end

  // First-word-fall-through event FIFO.
  assign ev_valid = (count_q != '0);
  assign pop      = ev_valid && ev_ready;
  assign ev_code  = ev_valid ? mem[rptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= g_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
